// File: rtl/ethernet_rx_deframer_pkg.sv
// Shared Ethernet framing constants: deframer state encoding, SFD and CRC-32 parameters.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package ethernet_rx_deframer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_DROP     = 2'd3
   } rx_state_t;

   localparam logic [7:0]  SFD             = 8'hD5;
   localparam int          SFD_BITS        = 8;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

   // One step of the reflected (LSB-first) CRC-32 shift register.
   function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic b);
      return (crc >> 1) ^ ((crc[0] ^ b) ? CRC32_POLY_REFL : 32'h0);
   endfunction

endpackage

// File: rtl/ethernet_rx_deframer_crc32_serial.sv
// Serial reflected CRC-32, one bit per enabled cycle; the register is not complemented.
// Latency: o_crc reflects a bit one cycle after it is presented with i_en.
// Backpressure: none; i_en gates updates, i_init has priority over i_en.
module ethernet_rx_deframer_crc32_serial
   import ethernet_rx_deframer_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_init,
   input  logic        i_en,
   input  logic        i_bit,
   output logic [31:0] o_crc
);

   // Seed on reset or frame start, otherwise fold in one bit per enable.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_init) begin
         o_crc <= CRC32_INIT;
      end else if (i_en) begin
         o_crc <= crc32_step(o_crc, i_bit);
      end
   end

endmodule

// File: rtl/ethernet_rx_deframer.sv
// Serial-bit to byte deframer: preamble/SFD hunt, LSB-first octet assembly, CRC-32 and length/alignment status.
// Latency: byte strobe 1 cycle after its 8th bit; eof 1 cycle after carrier loss is sampled.
// Backpressure: none; the line cannot be stalled, so downstream must accept every strobe.
module ethernet_rx_deframer
   import ethernet_rx_deframer_pkg::*;
#(
   parameter int MIN_PREAMBLE_BITS = 24,
   parameter int MAX_PREAMBLE_BITS = 72,
   parameter int MIN_FRAME_BYTES   = 64,
   parameter int MAX_FRAME_BYTES   = 1522
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_bit,
   input  logic        i_bit_valid,
   input  logic        i_carrier,
   output logic [7:0]  o_byte,
   output logic        o_byte_valid,
   output logic        o_sof,
   output logic        o_eof,
   output logic        o_fcs_ok,
   output logic        o_err_len,
   output logic        o_err_align,
   output logic [10:0] o_byte_count
);

   // pre_cnt includes the SFD's own 8 bits, so the lock threshold adds them back on.
   localparam logic [6:0]  PRE_LOCK  = 7'(MIN_PREAMBLE_BITS + SFD_BITS);
   localparam logic [6:0]  PRE_MAX   = 7'(MAX_PREAMBLE_BITS);
   localparam logic [10:0] MIN_BYTES = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0] MAX_BYTES = 11'(MAX_FRAME_BYTES);

   rx_state_t   state_q, state_d;
   logic [7:0]  sr_q;
   logic [6:0]  pre_cnt_q;
   logic [2:0]  bit_cnt_q;
   logic [10:0] byte_cnt_q;
   logic [31:0] crc;

   logic        sample, lock, give_up, byte_done, giant;
   logic [7:0]  sr_next;
   logic [6:0]  pre_cnt_inc;
   logic [2:0]  bit_cnt_inc;
   logic        crc_init, crc_en;
   logic        stb_d, sof_d, eof_d, fcs_ok_d, err_len_d, err_align_d;
   logic [10:0] count_d;

   assign sample      = i_carrier & i_bit_valid;
   assign sr_next     = {i_bit, sr_q[7:1]};
   assign pre_cnt_inc = (pre_cnt_q == 7'h7F) ? pre_cnt_q : pre_cnt_q + 7'd1;
   assign bit_cnt_inc = bit_cnt_q + 3'd1;
   assign lock        = (sr_next == SFD) && (pre_cnt_inc >= PRE_LOCK);
   assign give_up     = (pre_cnt_inc >= PRE_MAX);
   assign byte_done   = (bit_cnt_inc == 3'd0);
   // The octet that would push the count past the maximum is the first one not delivered.
   assign giant       = byte_done && (byte_cnt_q >= MAX_BYTES);

   ethernet_rx_deframer_crc32_serial u_crc (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_init (crc_init),
      .i_en   (crc_en),
      .i_bit  (i_bit),
      .o_crc  (crc)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: carrier loss always wins, then per-bit lock / give-up / giant decisions.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (i_carrier) state_d = ST_PREAMBLE;
         ST_PREAMBLE: begin
            if (!i_carrier)           state_d = ST_IDLE;
            else if (sample && lock)  state_d = ST_DATA;
            else if (sample && give_up) state_d = ST_DROP;
         end
         ST_DATA: begin
            if (!i_carrier)           state_d = ST_IDLE;
            else if (sample && giant) state_d = ST_DROP;
         end
         ST_DROP:     if (!i_carrier) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output decode: CRC control, next-cycle byte strobe, and eof status snapshot.
   always_comb begin
      crc_init    = 1'b0;
      crc_en      = 1'b0;
      stb_d       = 1'b0;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
      fcs_ok_d    = 1'b0;
      err_len_d   = 1'b0;
      err_align_d = 1'b0;
      count_d     = 11'd0;
      case (state_q)
         ST_PREAMBLE: crc_init = sample & lock;
         ST_DATA: begin
            if (!i_carrier) begin
               eof_d       = 1'b1;
               fcs_ok_d    = (crc == CRC32_RESIDUE) && (bit_cnt_q == 3'd0);
               err_len_d   = (byte_cnt_q < MIN_BYTES);
               err_align_d = (bit_cnt_q != 3'd0);
               count_d     = byte_cnt_q;
            end else if (sample) begin
               crc_en = 1'b1;
               stb_d  = byte_done & ~giant;
               sof_d  = byte_done & ~giant & (byte_cnt_q == 11'd0);
            end
         end
         ST_DROP: begin
            if (!i_carrier) begin
               eof_d       = 1'b1;
               err_len_d   = 1'b1;
               err_align_d = (bit_cnt_q != 3'd0);
               count_d     = byte_cnt_q;
            end
         end
         default: ;
      endcase
   end

   // Shift register and counters; a new hunt clears everything left over from the last frame.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sr_q       <= 8'd0;
         pre_cnt_q  <= 7'd0;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 11'd0;
      end else if (state_q == ST_IDLE) begin
         sr_q       <= 8'd0;
         pre_cnt_q  <= 7'd0;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 11'd0;
      end else if (sample) begin
         sr_q <= sr_next;
         if (state_q == ST_PREAMBLE) begin
            pre_cnt_q <= pre_cnt_inc;
            if (lock) bit_cnt_q <= 3'd0;
         end else if (state_q == ST_DATA) begin
            bit_cnt_q <= bit_cnt_inc;
            if (byte_done && byte_cnt_q != 11'h7FF) byte_cnt_q <= byte_cnt_q + 11'd1;
         end
      end
   end

   // Output registers; status fields are only non-zero alongside eof.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_byte       <= 8'd0;
         o_byte_valid <= 1'b0;
         o_sof        <= 1'b0;
         o_eof        <= 1'b0;
         o_fcs_ok     <= 1'b0;
         o_err_len    <= 1'b0;
         o_err_align  <= 1'b0;
         o_byte_count <= 11'd0;
      end else begin
         if (stb_d) o_byte <= sr_next;
         o_byte_valid <= stb_d;
         o_sof        <= sof_d;
         o_eof        <= eof_d;
         o_fcs_ok     <= fcs_ok_d;
         o_err_len    <= err_len_d;
         o_err_align  <= err_align_d;
         o_byte_count <= count_d;
      end
   end

endmodule

// File: tb/tb_ethernet_rx_deframer.sv
// Directed bench for ethernet_rx_deframer: builds frames with a reference FCS and checks strobes and eof status.
// Latency: n/a.
// Backpressure: n/a.
module tb_ethernet_rx_deframer;

   logic        clk = 1'b0;
   logic        rst, bit_in, bit_valid, carrier;
   logic [7:0]  o_byte;
   logic        o_byte_valid, o_sof, o_eof, o_fcs_ok, o_err_len, o_err_align;
   logic [10:0] o_byte_count;

   always #5 clk = ~clk;

   ethernet_rx_deframer dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_bit        (bit_in),
      .i_bit_valid  (bit_valid),
      .i_carrier    (carrier),
      .o_byte       (o_byte),
      .o_byte_valid (o_byte_valid),
      .o_sof        (o_sof),
      .o_eof        (o_eof),
      .o_fcs_ok     (o_fcs_ok),
      .o_err_len    (o_err_len),
      .o_err_align  (o_err_align),
      .o_byte_count (o_byte_count)
   );

   int compared   = 0;
   int mismatched = 0;

   // Monitor state, written only by the monitor process.
   int          strb_tot = 0, sof_tot = 0, sof_first_tot = 0, eof_tot = 0, frm_idx = 0;
   logic [7:0]  rx_byte [0:2047];
   logic        last_fcs_ok = 1'b0, last_err_len = 1'b0, last_err_align = 1'b0;
   logic [10:0] last_count = 11'd0;

   // Snapshots taken before each frame.
   int s_strb, s_sof, s_sof_first, s_eof;

   logic [7:0] frm [$];

   // Sample outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (o_byte_valid) begin
         if (frm_idx < 2048) rx_byte[frm_idx] <= o_byte;
         if (o_sof) begin
            sof_tot <= sof_tot + 1;
            if (frm_idx == 0) sof_first_tot <= sof_first_tot + 1;
         end
         strb_tot <= strb_tot + 1;
         frm_idx  <= frm_idx + 1;
      end
      if (o_eof) begin
         eof_tot        <= eof_tot + 1;
         last_fcs_ok    <= o_fcs_ok;
         last_err_len   <= o_err_len;
         last_err_align <= o_err_align;
         last_count     <= o_byte_count;
         frm_idx        <= 0;
      end
      if (rst) frm_idx <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Reference FCS: bytewise reflected CRC-32, complemented, sent LSB byte first.
   task automatic build_frame(input int total, input int seed);
      logic [31:0] c;
      frm.delete();
      for (int i = 0; i < total - 4; i++) frm.push_back(8'((i * 13 + seed) & 255));
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < total - 4; i++) begin
         c = c ^ {24'd0, frm[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      c = ~c;
      frm.push_back(c[7:0]);
      frm.push_back(c[15:8]);
      frm.push_back(c[23:16]);
      frm.push_back(c[31:24]);
   endtask

   task automatic drive_bit(input logic b, input int gap);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         bit_valid = 1'b0;
      end
      @(negedge clk);
      bit_in    = b;
      bit_valid = 1'b1;
   endtask

   // Carrier up, preamble, optional SFD, frame bytes, dribble bits, carrier down.
   task automatic send_head(input int pre_bits, input logic sfd, input int gap);
      logic [7:0] sfd_v;
      sfd_v = 8'hD5;
      @(negedge clk);
      carrier   = 1'b1;
      bit_valid = 1'b0;
      for (int i = 0; i < pre_bits; i++) drive_bit((i % 2) == 0, gap);
      if (sfd) for (int k = 0; k < 8; k++) drive_bit(sfd_v[k], gap);
   endtask

   task automatic send_frame(input int pre_bits, input logic sfd, input int dribble, input int gap);
      send_head(pre_bits, sfd, gap);
      foreach (frm[j]) for (int k = 0; k < 8; k++) drive_bit(frm[j][k], gap);
      for (int k = 0; k < dribble; k++) drive_bit((k % 2) == 0, gap);
      @(negedge clk);
      bit_valid = 1'b0;
      carrier   = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic snap();
      s_strb      = strb_tot;
      s_sof       = sof_tot;
      s_sof_first = sof_first_tot;
      s_eof       = eof_tot;
   endtask

   // exp_cnt < 0 skips the byte-count comparison.
   task automatic check_frame(input string tag, input int exp_strb, input int exp_eof,
                              input logic exp_fcs, input logic exp_len, input logic exp_align,
                              input int exp_cnt);
      chk({tag, "_strobes"}, 32'(strb_tot - s_strb), 32'(exp_strb));
      chk({tag, "_eofs"},    32'(eof_tot - s_eof),   32'(exp_eof));
      if (exp_strb > 0) begin
         chk({tag, "_sof_cnt"},   32'(sof_tot - s_sof),             32'd1);
         chk({tag, "_sof_first"}, 32'(sof_first_tot - s_sof_first), 32'd1);
      end else begin
         chk({tag, "_sof_cnt"},   32'(sof_tot - s_sof),             32'd0);
      end
      if (exp_eof > 0) begin
         chk({tag, "_fcs_ok"},    32'(last_fcs_ok),    32'(exp_fcs));
         chk({tag, "_err_len"},   32'(last_err_len),   32'(exp_len));
         chk({tag, "_err_align"}, 32'(last_err_align), 32'(exp_align));
         if (exp_cnt >= 0) chk({tag, "_count"}, 32'(last_count), 32'(exp_cnt));
      end
   endtask

   task automatic check_data(input string tag, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) if (rx_byte[i] !== frm[i]) bad++;
      chk({tag, "_data"}, 32'(bad), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      carrier   = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({o_byte, o_byte_valid, o_sof, o_eof, o_fcs_ok,
                                o_err_len, o_err_align, o_byte_count}), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Good 64-byte frame after a full 56-bit preamble.
      build_frame(64, 1);
      snap();
      send_frame(56, 1'b1, 0, 0);
      check_frame("good64", 64, 1, 1'b1, 1'b0, 1'b0, 64);
      check_data("good64", 64);

      // Same frame with one payload bit flipped.
      build_frame(64, 1);
      frm[5] = frm[5] ^ 8'h08;
      snap();
      send_frame(56, 1'b1, 0, 0);
      check_frame("bitflip", 64, 1, 1'b0, 1'b0, 1'b0, 64);

      // Short preamble: SFD arrives before enough alternating bits, no lock, no eof.
      frm.delete();
      snap();
      send_frame(20, 1'b1, 0, 0);
      check_frame("short_pre", 0, 0, 1'b0, 1'b0, 1'b0, -1);

      // Endless preamble: give up, eof flags a length error with zero bytes.
      frm.delete();
      snap();
      send_frame(80, 1'b0, 0, 0);
      check_frame("long_pre", 0, 1, 1'b0, 1'b1, 1'b0, 0);

      // Runt: 40 bytes with valid FCS.
      build_frame(40, 7);
      snap();
      send_frame(56, 1'b1, 0, 0);
      check_frame("runt40", 40, 1, 1'b1, 1'b1, 1'b0, 40);

      // Giant: 1600 bytes, only the first 1522 are delivered.
      build_frame(1600, 3);
      snap();
      send_frame(56, 1'b1, 0, 0);
      check_frame("giant", 1522, 1, 1'b0, 1'b1, 1'b0, -1);
      check_data("giant", 1522);

      // Good frame followed by 3 dribble bits.
      build_frame(64, 9);
      snap();
      send_frame(56, 1'b1, 3, 0);
      check_frame("dribble", 64, 1, 1'b0, 1'b0, 1'b1, 64);

      // Reset in the middle of DATA: outputs clear, no eof.
      build_frame(64, 11);
      snap();
      send_head(56, 1'b1, 0);
      for (int j = 0; j < 10; j++) for (int k = 0; k < 8; k++) drive_bit(frm[j][k], 0);
      @(negedge clk);
      bit_valid = 1'b0;
      carrier   = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      chk("midrst_outputs", 32'({o_byte, o_byte_valid, o_sof, o_eof, o_fcs_ok,
                                 o_err_len, o_err_align, o_byte_count}), 32'd0);
      chk("midrst_strobes", 32'(strb_tot - s_strb), 32'd10);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_eof", 32'(eof_tot - s_eof), 32'd0);

      // Next frame decodes cleanly, with idle gaps between every bit.
      build_frame(64, 21);
      snap();
      send_frame(56, 1'b1, 0, 2);
      check_frame("gapped", 64, 1, 1'b1, 1'b0, 1'b0, 64);
      check_data("gapped", 64);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
